simon_game_controller: RTL

//  Parametrised top-level Simon game FSM: sequences title, load delay, sequence display,

---
 rtl/simon_game_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/simon_game_controller.sv
// Simon game top-level sequencer: title, load delay, display, player entry, pause/retry, win/lose.
// Level, lives, score and the inter-state delay counter are all owned here.
//   state      | meaning
//   START      | title screen, game registers reloaded every cycle
//   STARTWAIT  | waiting for go release
//   LOAD       | fixed delay before first display
//   DISPLAY    | sequenceDisplay playing level+1 items
//   MOVECURSOR | player entering the sequence
//   WAIT       | pause after a correct round
//   RETRY      | pause after a wrong entry, same size replays
//   WIN/LOSE   | end screens, WINWAIT/LOSEWAIT wait for go release
module simon_game_controller #(
    parameter int SIZE_W      = 4,
    parameter int MAX_SEQ     = 10,
    parameter int LIVES       = 3,
    parameter int LIVES_W     = 2,
    parameter int CNT_W       = 27,
    parameter int LOAD_CYCLES = 100000000,
    parameter int WAIT_CYCLES = 25000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              go,
    input  logic [SIZE_W-1:0] startLevel,
    input  logic              doneSequence,
    input  logic              gameOver,
    input  logic              correct,
    output logic [SIZE_W-1:0] sequenceSize,
    output logic              displaySequence,
    output logic              drawCursor,
    output logic              startReading,
    output logic              drawControlReset,
    output logic              drawTitle,
    output logic              drawWin,
    output logic              drawLose,
    output logic [LIVES_W-1:0] livesLeft,
    output logic [SIZE_W-1:0] score
);

    typedef enum logic [3:0] {
        S_START      = 4'd0,
        S_STARTWAIT  = 4'd1,
        S_LOAD       = 4'd2,
        S_DISPLAY    = 4'd3,
        S_MOVECURSOR = 4'd4,
        S_WAIT       = 4'd5,
        S_RETRY      = 4'd6,
        S_WIN        = 4'd7,
        S_WINWAIT    = 4'd8,
        S_LOSE       = 4'd9,
        S_LOSEWAIT   = 4'd10
    } state_t;

    localparam logic [SIZE_W-1:0]  MAX_SZ     = SIZE_W'(MAX_SEQ);
    localparam logic [SIZE_W-1:0]  TOP_LEVEL  = SIZE_W'(MAX_SEQ - 1);
    localparam logic [CNT_W-1:0]   LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [SIZE_W-1:0] level;
    logic [SIZE_W-1:0] level_p1;
    logic              counting;

    assign level_p1 = level + SIZE_W'(1);
    assign counting = (state == S_LOAD) || (state == S_WAIT) || (state == S_RETRY);

    always_comb begin
        state_nx = state;
        case (state)
            S_START:      if (go) state_nx = S_STARTWAIT;
            S_STARTWAIT:  if (!go) state_nx = S_LOAD;
            S_LOAD:       if (cnt == LOAD_LAST) state_nx = S_DISPLAY;
            S_DISPLAY:    if (doneSequence) state_nx = S_MOVECURSOR;
            S_MOVECURSOR: begin
                // A wrong entry outranks a simultaneous correct flag.
                if (gameOver)
                    state_nx = (livesLeft <= LIVES_W'(1)) ? S_LOSE : S_RETRY;
                else if (correct)
                    state_nx = (level_p1 == MAX_SZ) ? S_WIN : S_WAIT;
            end
            S_WAIT, S_RETRY: if (cnt == WAIT_LAST) state_nx = S_DISPLAY;
            S_WIN:        if (go) state_nx = S_WINWAIT;
            S_WINWAIT:    if (!go) state_nx = S_START;
            S_LOSE:       if (go) state_nx = S_LOSEWAIT;
            S_LOSEWAIT:   if (!go) state_nx = S_START;
            default:      state_nx = S_START;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= S_START;
            cnt       <= '0;
            livesLeft <= LIVES_INIT;
            score     <= '0;
            level     <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= '0;
            else if (counting && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + CNT_W'(1);

            case (state)
                S_START: begin
                    level     <= (startLevel > TOP_LEVEL) ? TOP_LEVEL : startLevel;
                    livesLeft <= LIVES_INIT;
                    score     <= '0;
                end
                S_MOVECURSOR: begin
                    if (gameOver) begin
                        if (livesLeft != '0)
                            livesLeft <= livesLeft - LIVES_W'(1);
                    end else if (correct) begin
                        if (score != MAX_SZ)
                            score <= score + SIZE_W'(1);
                        if ((level_p1 != MAX_SZ) && (level != MAX_SZ))
                            level <= level_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sequenceSize     = '0;
        displaySequence  = 1'b0;
        drawCursor       = 1'b1;
        startReading     = 1'b1;
        drawControlReset = 1'b1;
        drawTitle        = 1'b0;
        drawWin          = 1'b0;
        drawLose         = 1'b0;
        case (state)
            S_START:      begin drawControlReset = 1'b0; drawTitle = 1'b1; end
            S_STARTWAIT:  drawTitle = 1'b1;
            S_DISPLAY:    begin sequenceSize = level_p1; displaySequence = 1'b1; end
            S_MOVECURSOR: begin
                sequenceSize = level_p1;
                drawCursor   = 1'b0;
                startReading = 1'b0;
            end
            S_WAIT, S_RETRY:      drawControlReset = 1'b0;
            S_WIN, S_WINWAIT:     drawWin = 1'b1;
            S_LOSE, S_LOSEWAIT:   drawLose = 1'b1;
            default: ;
        endcase
    end

endmodule
